ctrl_hazard_pipe: RTL and testbench

CTRL_HAZARD_PIPE -- requirements
Module: ctrl_hazard_pipe

---
 rtl/ctrl_hazard_pipe.sv | 141 ++++++++++++++
 tb/tb_ctrl_hazard_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_hazard_pipe.sv
// ctrl_hazard_pipe
// Pipeline register for the decoded control bundle with hazard handling.
// On each rising edge the stage either loads the incoming control bundle,
// holds it (stall), kills it (flush), or inserts a run of zero bundles
// (bubbles) requested through bubble_req/bubble_len.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   *_in, alu_control_in          incoming control bundle
//   pc_src_select_in              incoming PC source select
//   bubble_req, bubble_len        bubble request and requested length
//   stall, flush                  hold / kill stage contents
//   *_out, alu_control_out        registered control bundle
//   bubble_active                 high while bubbles remain to be issued
//   bubble_left                   bubble cycles remaining after this cycle
//   bubble_total                  saturating count of bubble zero bundles
module ctrl_hazard_pipe #(
  parameter int ALU_CTRL_W = 4,
  parameter int BUBBLE_MAX = 3,
  parameter int CNT_W      = 4,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_enable_in,
  input  logic                  mem_write_enable_in,
  input  logic                  mem_to_reg_select_in,
  input  logic                  alu_src_in,
  input  logic                  status_bit_in,
  input  logic [ALU_CTRL_W-1:0] alu_control_in,
  input  logic                  pc_src_select_in,
  input  logic                  bubble_req,
  input  logic [CNT_W-1:0]      bubble_len,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  reg_write_enable_out,
  output logic                  mem_write_enable_out,
  output logic                  mem_to_reg_select_out,
  output logic                  alu_src_select_out,
  output logic                  status_bits_out,
  output logic                  pc_src_select_out,
  output logic [ALU_CTRL_W-1:0] alu_control_out,
  output logic                  bubble_active,
  output logic [CNT_W-1:0]      bubble_left,
  output logic [STAT_W-1:0]     bubble_total
);

  typedef enum logic {
    PASS   = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  status;
    logic                  pc_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } bundle_t;

  state_t              state_q, state_d;
  bundle_t             bundle_q, bundle_d, bundle_in;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [STAT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]    len_eff;
  logic [STAT_W-1:0]   total_inc;

  always_comb begin
    bundle_in = '{reg_write:  reg_write_enable_in,
                  mem_write:  mem_write_enable_in,
                  mem_to_reg: mem_to_reg_select_in,
                  alu_src:    alu_src_in,
                  status:     status_bit_in,
                  pc_src:     pc_src_select_in,
                  alu_ctrl:   alu_control_in};

    // Requests longer than BUBBLE_MAX are clipped rather than rejected.
    len_eff   = (bubble_len > CNT_W'(BUBBLE_MAX)) ? CNT_W'(BUBBLE_MAX) : bubble_len;
    total_inc = (total_q == '1) ? total_q : total_q + STAT_W'(1);

    bundle_d = bundle_q;
    state_d  = state_q;
    left_d   = left_q;
    total_d  = total_q;

    if (flush) begin
      bundle_d = '0;
      state_d  = PASS;
      left_d   = '0;
    end else if (!stall) begin
      case (state_q)
        BUBBLE: begin
          // bubble_req is deliberately ignored here: no queuing or extension.
          bundle_d = '0;
          left_d   = left_q - CNT_W'(1);
          total_d  = total_inc;
          if (left_q == CNT_W'(1)) state_d = PASS;
        end
        default: begin
          if (bubble_req && (bubble_len != '0)) begin
            // The accepting edge itself is the first bubble.
            bundle_d = '0;
            left_d   = len_eff - CNT_W'(1);
            total_d  = total_inc;
            state_d  = (len_eff > CNT_W'(1)) ? BUBBLE : PASS;
          end else begin
            bundle_d = bundle_in;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PASS;
      bundle_q <= '0;
      left_q   <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      left_q   <= left_d;
      total_q  <= total_d;
    end
  end

  assign reg_write_enable_out  = bundle_q.reg_write;
  assign mem_write_enable_out  = bundle_q.mem_write;
  assign mem_to_reg_select_out = bundle_q.mem_to_reg;
  assign alu_src_select_out    = bundle_q.alu_src;
  assign status_bits_out       = bundle_q.status;
  assign pc_src_select_out     = bundle_q.pc_src;
  assign alu_control_out       = bundle_q.alu_ctrl;
  assign bubble_active         = (state_q == BUBBLE);
  assign bubble_left           = left_q;
  assign bubble_total          = total_q;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Scoreboard bench for ctrl_hazard_pipe: a reference model tracks the
// number of zero bundles still owed and queues the expected outputs after
// each edge; a monitor pops and compares on the falling edge.
module tb_ctrl_hazard_pipe;

  localparam int AW    = 4;
  localparam int BMAX  = 3;
  localparam int CW    = 4;
  localparam int SW    = 6;
  localparam int OUT_W = 6 + AW + 1 + CW + SW;

  logic          clk = 1'b0;
  logic          reset;
  logic          rw_i, mw_i, m2r_i, as_i, st_i, pcs_i;
  logic [AW-1:0] alu_i;
  logic          bubble_req;
  logic [CW-1:0] bubble_len;
  logic          stall, flush;
  logic          rw_o, mw_o, m2r_o, as_o, st_o, pcs_o;
  logic [AW-1:0] alu_o;
  logic          bubble_active;
  logic [CW-1:0] bubble_left;
  logic [SW-1:0] bubble_total;

  logic [OUT_W-1:0] exp_q[$];
  int unsigned      n_vec  = 0;
  int unsigned      n_fail = 0;
  bit               done   = 1'b0;

  ctrl_hazard_pipe #(
    .ALU_CTRL_W(AW),
    .BUBBLE_MAX(BMAX),
    .CNT_W(CW),
    .STAT_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_write_enable_in(rw_i),
    .mem_write_enable_in(mw_i),
    .mem_to_reg_select_in(m2r_i),
    .alu_src_in(as_i),
    .status_bit_in(st_i),
    .alu_control_in(alu_i),
    .pc_src_select_in(pcs_i),
    .bubble_req(bubble_req),
    .bubble_len(bubble_len),
    .stall(stall),
    .flush(flush),
    .reg_write_enable_out(rw_o),
    .mem_write_enable_out(mw_o),
    .mem_to_reg_select_out(m2r_o),
    .alu_src_select_out(as_o),
    .status_bits_out(st_o),
    .pc_src_select_out(pcs_o),
    .alu_control_out(alu_o),
    .bubble_active(bubble_active),
    .bubble_left(bubble_left),
    .bubble_total(bubble_total)
  );

  always #5 clk = ~clk;

  // Reference model: "owed" counts zero bundles still to be issued.
  initial begin
    logic [6+AW-1:0] m_bun;
    int              owed;
    int              tot;
    int              len;
    m_bun = '0;
    owed  = 0;
    tot   = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_bun = '0; owed = 0; tot = 0;
      end else if (flush) begin
        m_bun = '0; owed = 0;
      end else if (stall) begin
        // everything holds
      end else if (owed > 0) begin
        m_bun = '0;
        owed  = owed - 1;
        if (tot < (1 << SW) - 1) tot = tot + 1;
      end else if (bubble_req && bubble_len != 0) begin
        len   = (int'(bubble_len) > BMAX) ? BMAX : int'(bubble_len);
        m_bun = '0;
        owed  = len - 1;
        if (tot < (1 << SW) - 1) tot = tot + 1;
      end else begin
        m_bun = {rw_i, mw_i, m2r_i, as_i, st_i, pcs_i, alu_i};
      end
      exp_q.push_back({m_bun, 1'(owed != 0), CW'(owed), SW'(tot)});
    end
  end

  // Monitor: one output vector per cycle, compared mid-cycle.
  initial begin
    logic [OUT_W-1:0] act, exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {rw_o, mw_o, m2r_o, as_o, st_o, pcs_o, alu_o,
               bubble_active, bubble_left, bubble_total};
        n_vec++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got ctl=%b alu=%h act=%b left=%0d tot=%0d, want ctl=%b alu=%h act=%b left=%0d tot=%0d",
                   $time, act[OUT_W-1 -: 6], act[OUT_W-7 -: AW], act[CW+SW],
                   act[SW +: CW], act[SW-1:0], exp[OUT_W-1 -: 6],
                   exp[OUT_W-7 -: AW], exp[CW+SW], exp[SW +: CW], exp[SW-1:0]);
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit f, input bit s, input bit q,
                     input int l, input bit keep_bundle);
    reset      = r;
    flush      = f;
    stall      = s;
    bubble_req = q;
    bubble_len = CW'(l);
    if (!keep_bundle) begin
      {rw_i, mw_i, m2r_i, as_i, st_i, pcs_i} = 6'($urandom);
      alu_i = AW'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; bubble_req = 1'b0;
    bubble_len = '0;
    {rw_i, mw_i, m2r_i, as_i, st_i, pcs_i} = '0;
    alu_i = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    // passthrough with a known bundle
    {rw_i, mw_i, m2r_i, as_i, st_i, pcs_i} = 6'b100000;
    alu_i = 4'hA;
    cyc(0, 0, 0, 0, 0, 1);
    // 3-cycle bubble, with a request during the bubble that must be ignored
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // clipped length, then zero length
    cyc(0, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // single-cycle bubble stays in pass state
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // stall mid-bubble
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 1, 1, 2, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // flush with one bubble left
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // reset mid-bubble together with stall and request
    cyc(0, 0, 0, 1, 3, 0);
    cyc(1, 0, 1, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // flush and stall together over a nonzero held bundle
    {rw_i, mw_i, m2r_i, as_i, st_i, pcs_i} = 6'b111111;
    alu_i = 4'hF;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // random traffic; rare resets let the 6-bit total reach saturation
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 15)), 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

endmodule
